sdram_arbiter: RTL

//  Top-level scheduler for the SDRAM controller. Sequences power-up init, then grants the single SDRAM

---
 rtl/sdram_arbiter_pkg.sv | 21 ++
 rtl/sdram_arb_wdog.sv | 25 ++
 rtl/sdram_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM controller definitions: pin command encodings and arbiter states.
// Used by the arbiter and the init/aref/write/read engines.
package sdram_arbiter_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_arb_wdog.sv
// Grant watchdog: counts cycles of the current grant and pulses expire on the
// GRANT_TMO-th busy cycle if the owner has not signalled done in that cycle.
module sdram_arb_wdog #(
  parameter int GRANT_TMO = 1023
) (
  input  logic sdram_clk,
  input  logic rst,
  input  logic busy,
  input  logic done,
  output logic expire
);

  localparam int CW = $clog2(GRANT_TMO + 1);

  // cnt = busy cycles already completed in this grant
  logic [CW-1:0] cnt;

  assign expire = busy && !done && (cnt == CW'(GRANT_TMO - 1));

  always_ff @(posedge sdram_clk) begin
    if (rst || !busy) cnt <= '0;
    else              cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus scheduler: init sequencing, then one owner (refresh/write/read) at a time,
// with registered pins. Define SDRAM_ARB_RR_EN for write/read round-robin.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int BA_BITS   = 2,
  parameter int DQ_BITS   = 16,
  parameter int GRANT_TMO = 1023
) (
  input  logic                 sdram_clk,
  input  logic                 rst,
  input  logic                 init_done,
  input  logic [3:0]           init_cmd,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic                 aref_req,
  output logic                 aref_en,
  input  logic                 aref_done,
  input  logic [3:0]           aref_cmd,
  input  logic                 wr_req,
  output logic                 wr_en,
  input  logic                 wr_end,
  input  logic [3:0]           wr_cmd,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [BA_BITS-1:0]   wr_ba,
  input  logic [7:0]           wr_data,
  input  logic                 rd_req,
  output logic                 rd_en,
  input  logic                 rd_end,
  input  logic [3:0]           rd_cmd,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic [BA_BITS-1:0]   rd_ba,
  output logic [3:0]           sdram_cmd,
  output logic [ADDR_BITS-1:0] sdram_addr,
  output logic [BA_BITS-1:0]   sdram_ba,
  output logic [DQ_BITS-1:0]   sdram_dq,
  output logic                 sdram_dq_oe,
  output logic                 tmo_err
);

  arb_state_t           state;
  logic                 busy, done, expire, grant_wr;
  logic [3:0]           src_cmd;
  logic [ADDR_BITS-1:0] src_addr;
  logic [BA_BITS-1:0]   src_ba;

  assign busy = (state == ST_AREF) || (state == ST_WRITE) || (state == ST_READ);

  always_comb begin
    done     = 1'b0;
    src_cmd  = CMD_NOP;
    src_addr = '0;
    src_ba   = '0;
    case (state)
      ST_INIT: begin
        src_cmd  = init_cmd;
        src_addr = init_addr;
      end
      ST_AREF: begin
        done    = aref_done;
        src_cmd = aref_cmd;
      end
      ST_WRITE: begin
        done     = wr_end;
        src_cmd  = wr_cmd;
        src_addr = wr_addr;
        src_ba   = wr_ba;
      end
      ST_READ: begin
        done     = rd_end;
        src_cmd  = rd_cmd;
        src_addr = rd_addr;
        src_ba   = rd_ba;
      end
      default: ;
    endcase
  end

`ifdef SDRAM_ARB_RR_EN
  // 1 = last write/read grant went to read, so write has the next turn
  logic last_rd;

  assign grant_wr = wr_req && (!rd_req || last_rd);

  always_ff @(posedge sdram_clk) begin
    if (rst)
      last_rd <= 1'b1;
    else if (state == ST_IDLE && !aref_req && (wr_req || rd_req))
      last_rd <= !grant_wr;
  end
`else
  assign grant_wr = wr_req;
`endif

  sdram_arb_wdog #(.GRANT_TMO(GRANT_TMO)) u_wdog (
    .sdram_clk (sdram_clk),
    .rst       (rst),
    .busy      (busy),
    .done      (done),
    .expire    (expire)
  );

  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      state       <= ST_INIT;
      aref_en     <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      sdram_cmd   <= CMD_NOP;
      sdram_addr  <= '0;
      sdram_ba    <= '0;
      sdram_dq    <= '0;
      sdram_dq_oe <= 1'b0;
      tmo_err     <= 1'b0;
    end else begin
      aref_en     <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      // a timed-out cycle is replaced by NOP with DQ released
      sdram_cmd   <= expire ? CMD_NOP : src_cmd;
      sdram_addr  <= src_addr;
      sdram_ba    <= src_ba;
      sdram_dq    <= (state == ST_WRITE) ? DQ_BITS'(wr_data) : '0;
      sdram_dq_oe <= (state == ST_WRITE) && !expire;
      if (expire) tmo_err <= 1'b1;
      case (state)
        ST_INIT: if (init_done) state <= ST_IDLE;
        ST_IDLE: begin
          if (aref_req) begin
            state   <= ST_AREF;
            aref_en <= 1'b1;
          end else if (grant_wr) begin
            state <= ST_WRITE;
            wr_en <= 1'b1;
          end else if (rd_req) begin
            state <= ST_READ;
            rd_en <= 1'b1;
          end
        end
        default: if (done || expire) state <= ST_IDLE;
      endcase
    end
  end

endmodule
